mult_seq_shift_add: RTL and testbench

//  Multi-cycle shift-and-add multiplier. One partial product per clock.

---
 rtl/mult_seq_shift_add.sv | 103 ++++++++++
 tb/tb_mult_seq_shift_add.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_shift_add.sv
// Sequential shift-and-add multiplier with a start/busy/done handshake.
// Optional two's-complement support is enabled with `define SIGNED_MODE_EN.
module mult_seq_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SIGNED_MODE_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] result;

`ifdef SIGNED_MODE_EN
  // Magnitude of the most-negative value is 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit operand.
  always_comb begin
    a_mag  = (signed_op && a[WIDTH-1]) ? WIDTH'(~a + 1'b1) : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? WIDTH'(~b + 1'b1) : b;
    neg_in = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
  end
`endif

  always_comb begin
    sum    = acc + (mb[0] ? ma : '0);
    result = neg ? (~sum + 1'b1) : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      ma      <= '0;
      mb      <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ma    <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            cnt   <= '0;
            neg   <= neg_in;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= sum;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Scoreboard bench for mult_seq_shift_add (WIDTH=8).
// Signed vectors run when SIGNED_MODE_EN is defined.
module tb_mult_seq_shift_add;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];

  mult_seq_shift_add #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SIGNED_MODE_EN
    .signed_op(signed_op),
`endif
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cyc %0d)",
                 cyc);
      end else begin
        chk("product", 32'(product), 32'(exp_q.pop_front()));
        chk("latency_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Caller is positioned at a negedge; E0 is the following posedge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic sop, input logic [2*W-1:0] exp,
                       input bit push);
    a = ta;
    b = tb_;
    signed_op = sop;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + 1 + W);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: got no done expected done within 40 cycles");
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    exp_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: max operands, busy held for W cycles
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
    for (int i = 0; i < W; i++) begin
      chk("busy_during_calc", 32'(busy), 32'd1);
      @(negedge clk);
    end
    drain();

    // 2: operand edge cases
    issue(8'h00, 8'hA5, 1'b0, 16'h0000, 1'b1);
    drain();
    issue(8'h01, 8'h80, 1'b0, 16'h0080, 1'b1);
    drain();

    // 3: start while busy is ignored; 4: back-to-back in done cycle
    issue(8'h03, 8'h04, 1'b0, 16'h000C, 1'b1);
    @(negedge clk);
    issue(8'h09, 8'h09, 1'b0, 16'h0000, 1'b0);
    wait_done();
    issue(8'h07, 8'h06, 1'b0, 16'h002A, 1'b1);
    drain();

    issue(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
    drain();

`ifdef SIGNED_MODE_EN
    issue(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
    drain();
    issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
    drain();
    issue(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
    drain();
    issue(8'h80, 8'h80, 1'b0, 16'h4000, 1'b1);
    drain();
`endif

    // 5: async reset mid-operation, no done afterwards
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_product", 32'(product), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
